boot_loader: RTL and testbench

- Sequencer that runs once after reset. It drains the UART RX FIFO, assembles a length-prefixed little-endian program image into 32-bit words, and writes them into instruction memory.
- While loading, it holds the RISC-V core in reset; after the last word it releases the core.
- Sits between the RX FIFO read port and the imem write port, beside the core wrapper. It owns RE_fifo until boot completes; the top mux hands RE_fifo to the core when boot_done=1.

---
 rtl/boot_loader_pkg.sv | 29 ++
 rtl/boot_loader_if.sv | 32 +++
 rtl/boot_loader_byte_assembler.sv | 33 +++
 rtl/boot_loader.sv | 143 ++++++++++++++
 tb/tb_boot_loader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, byte-count
// constants and the little-endian byte insertion helper.
package boot_pkg;

  typedef enum logic [2:0] {
    LEN_REQ = 3'd0,
    LEN_CAP = 3'd1,
    DAT_REQ = 3'd2,
    DAT_CAP = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } boot_state_e;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] insert_byte(
    input logic [31:0] word,
    input logic [1:0]  idx,
    input logic [7:0]  data
  );
    logic [31:0] res;
    res = word;
    res[{idx, 3'b000} +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Bus bundle between the boot loader, the RX FIFO read port and the imem
// write port.
interface boot_loader_if #(
  parameter int ADDR_W = 12
) ();

  logic              Empty;
  logic [7:0]        fifo_data_out;
  logic              RE_fifo;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  Empty,
    input  fifo_data_out,
    output RE_fifo,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output Empty,
    output fifo_data_out,
    input  RE_fifo,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/boot_loader_byte_assembler.sv
// Four-byte little-endian assembly register. o_word_next previews the word
// with the current byte inserted so the owner can act on the final byte.
module byte_assembler
  import boot_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_full
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [31:0] r_word;
  logic [1:0]  r_bc;

  assign o_word_next = insert_byte(r_word, r_bc, i_byte);
  assign o_full      = (r_bc == LAST_IDX);

  // Byte insertion; the 2-bit counter wraps so each phase starts at byte 0.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_word <= 32'd0;
      r_bc   <= 2'd0;
    end else if (i_load) begin
      r_word <= o_word_next;
      r_bc   <= r_bc + 2'd1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// One-shot loader: reads a length-prefixed little-endian image from the RX
// FIFO into imem, holding the core in reset until the last word is written.
module boot_loader
  import boot_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic          CLK,
  input  logic          RST_N,
  boot_loader_if.master bus,
  output logic          core_rst_n,
  output logic          boot_done,
  output logic          boot_err
);

  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  boot_state_e       r_state;
  logic [31:0]       r_len;
  logic [ADDR_W:0]   r_wcnt;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_core_rst_n;
  logic              r_boot_done;
  logic              r_boot_err;

  logic              w_req;
  logic              w_load;
  logic              w_full;
  logic [31:0]       w_word_next;
  logic [ADDR_W:0]   w_wcnt_inc;
  logic [32:0]       w_len_ext;

  // The FIFO returns data one cycle after the request, so the read enable
  // must follow Empty within the request cycle itself.
  assign w_req      = ((r_state == LEN_REQ) || (r_state == DAT_REQ)) && !bus.Empty;
  assign w_load     = (r_state == LEN_CAP) || (r_state == DAT_CAP);
  assign w_wcnt_inc = r_wcnt + {{ADDR_W{1'b0}}, 1'b1};
  assign w_len_ext  = {1'b0, w_word_next};

  assign bus.RE_fifo    = w_req;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign core_rst_n     = r_core_rst_n;
  assign boot_done      = r_boot_done;
  assign boot_err       = r_boot_err;

  byte_assembler u_asm (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .i_load      (w_load),
    .i_byte      (bus.fifo_data_out),
    .o_word_next (w_word_next),
    .o_full      (w_full)
  );

  // Load sequencer with registered strobes and status.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= LEN_REQ;
      r_len        <= 32'd0;
      r_wcnt       <= {(ADDR_W+1){1'b0}};
      r_imem_we    <= 1'b0;
      r_imem_addr  <= BASE_ADDR;
      r_imem_wdata <= 32'd0;
      r_core_rst_n <= 1'b0;
      r_boot_done  <= 1'b0;
      r_boot_err   <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        LEN_REQ: begin
          if (w_req) begin
            r_state <= LEN_CAP;
          end else begin
            r_state <= LEN_REQ;
          end
        end
        LEN_CAP: begin
          if (w_full) begin
            r_len <= w_word_next;
            if (w_word_next == 32'd0) begin
              r_state      <= DONE;
              r_boot_done  <= 1'b1;
              r_core_rst_n <= 1'b1;
            end else if (w_len_ext > CAPACITY) begin
              r_state    <= ERR;
              r_boot_err <= 1'b1;
            end else begin
              r_state <= DAT_REQ;
            end
          end else begin
            r_state <= LEN_REQ;
          end
        end
        DAT_REQ: begin
          if (w_req) begin
            r_state <= DAT_CAP;
          end else begin
            r_state <= DAT_REQ;
          end
        end
        DAT_CAP: begin
          if (w_full) begin
            r_state      <= WRITE;
            r_imem_we    <= 1'b1;
            r_imem_addr  <= BASE_ADDR + r_wcnt[ADDR_W-1:0];
            r_imem_wdata <= w_word_next;
          end else begin
            r_state <= DAT_REQ;
          end
        end
        WRITE: begin
          r_wcnt <= w_wcnt_inc;
          // Counter is one bit wider than the address so a full image ends cleanly.
          if (32'(w_wcnt_inc) == r_len) begin
            r_state      <= DONE;
            r_boot_done  <= 1'b1;
            r_core_rst_n <= 1'b1;
          end else begin
            r_state <= DAT_REQ;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        ERR: begin
          r_state <= ERR;
        end
        default: begin
          r_state      <= ERR;
          r_boot_err   <= 1'b1;
          r_boot_done  <= 1'b0;
          r_core_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: a behavioural RX FIFO feeds images and
// expected imem writes are queued up front and matched against observed ones.
module tb_boot_loader;

  localparam int ADDR_W = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic core_rst_n;
  logic boot_done;
  logic boot_err;

  boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(4'd0)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  always #5 CLK = ~CLK;

  logic [7:0] fifo_q[$];
  wr_t        exp_q[$];
  wr_t        obs_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int re_cnt, v_re_empty, v_re_consec, v_re_we, v_core_early, re_after_end;
  int done_cyc, err_cyc, stall_left, stall_max;
  bit prev_re;

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) fifo_q.push_back(w[8*i +: 8]);
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = a[ADDR_W-1:0];
    e.data = d;
    e.cyc  = 0;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    bus.Empty = 1'b1;
    bus.fifo_data_out = 8'h00;
    @(posedge CLK); #1;
  endtask

  task automatic release_reset();
    RST_N = 1'b1;
    re_cnt = 0; v_re_empty = 0; v_re_consec = 0; v_re_we = 0;
    v_core_early = 0; re_after_end = 0; done_cyc = -1; err_cyc = -1;
    stall_left = 0; prev_re = 1'b0;
    obs_q.delete();
    bus.Empty = (fifo_q.size() == 0);
  endtask

  // FIFO model and monitor; samples at negedge, updates Empty after posedge.
  task automatic drive(input int budget, input int stop_re, output bit timed_out);
    int cyc = 0;
    int tail = -1;
    wr_t o;
    timed_out = 1'b1;
    while (cyc < budget) begin
      @(negedge CLK);
      if (bus.RE_fifo && bus.Empty) v_re_empty++;
      if (bus.RE_fifo && prev_re) v_re_consec++;
      if (bus.RE_fifo && bus.imem_we) v_re_we++;
      if (core_rst_n && !boot_done) v_core_early++;
      if (bus.imem_we) begin
        o.addr = bus.imem_addr; o.data = bus.imem_wdata; o.cyc = cyc;
        obs_q.push_back(o);
      end
      if ((boot_done || boot_err) && tail < 0) begin
        tail = 4;
        if (boot_done) done_cyc = cyc;
        if (boot_err) err_cyc = cyc;
      end
      if (bus.RE_fifo) begin
        if (tail >= 0) re_after_end++;
        re_cnt++;
        if (fifo_q.size() > 0) bus.fifo_data_out = fifo_q.pop_front();
        stall_left = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      end
      prev_re = bus.RE_fifo;
      cyc++;
      if (tail == 0 || (stop_re > 0 && re_cnt >= stop_re)) begin
        timed_out = 1'b0;
        break;
      end
      if (tail > 0) tail--;
      @(posedge CLK); #1;
      bus.Empty = (fifo_q.size() == 0) || (stall_left > 0);
      if (stall_left > 0) stall_left--;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.RE_fifo !== 1'b0) begin n_errors++; $display("FAIL reset_re: got %b expected 0", bus.RE_fifo); end
    n_checks++; if (bus.imem_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b expected 0", bus.imem_we); end
    n_checks++; if (bus.imem_addr !== 4'd0) begin n_errors++; $display("FAIL reset_addr: got %h expected 0", bus.imem_addr); end
    n_checks++; if (bus.imem_wdata !== 32'd0) begin n_errors++; $display("FAIL reset_wdata: got %h expected 0", bus.imem_wdata); end
    n_checks++; if (core_rst_n !== 1'b0) begin n_errors++; $display("FAIL reset_core: got %b expected 0", core_rst_n); end
    n_checks++; if (boot_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", boot_done); end
    n_checks++; if (boot_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", boot_err); end
  endtask

  task automatic test_len_zero();
    bit to;
    fifo_q.delete(); exp_q.delete(); stall_max = 0;
    push_word(32'd0);
    apply_reset(); release_reset();
    drive(200, 0, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL len0_timeout: got %b expected 0", to); end
    n_checks++; if (re_cnt != 4) begin n_errors++; $display("FAIL len0_re_count: got %0d expected 4", re_cnt); end
    n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL len0_writes: got %0d expected 0", obs_q.size()); end
    n_checks++; if (done_cyc != 8) begin n_errors++; $display("FAIL len0_done_cycle: got %0d expected 8", done_cyc); end
    n_checks++; if (core_rst_n !== 1'b1) begin n_errors++; $display("FAIL len0_core: got %b expected 1", core_rst_n); end
  endtask

  task automatic test_two_words(input bit stall);
    bit to;
    wr_t e, o;
    int first_cyc = -1;
    int last_cyc = -1;
    fifo_q.delete(); exp_q.delete(); stall_max = stall ? 5 : 0;
    push_word(32'd2); push_word(32'h12345678); push_word(32'hDEADBEEF);
    push_exp(0, 32'h12345678); push_exp(1, 32'hDEADBEEF);
    apply_reset(); release_reset();
    drive(1000, 0, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL two_timeout stall=%0d: got %b expected 0", stall, to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL two_missing stall=%0d: no write, expected addr %h data %h", stall, e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (first_cyc < 0) first_cyc = o.cyc;
        last_cyc = o.cyc;
        if (o.addr !== e.addr || o.data !== e.data) begin
          n_errors++; $display("FAIL two_write stall=%0d: got %h/%h expected %h/%h", stall, o.addr, o.data, e.addr, e.data);
        end
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL two_extra stall=%0d: got %0d extra writes expected 0", stall, obs_q.size()); end
    if (!stall) begin
      n_checks++; if (first_cyc != 16) begin n_errors++; $display("FAIL two_first_cycle: got %0d expected 16", first_cyc); end
      n_checks++; if (last_cyc - first_cyc != 9) begin n_errors++; $display("FAIL two_spacing: got %0d expected 9", last_cyc - first_cyc); end
    end
    n_checks++; if (done_cyc != last_cyc + 1) begin n_errors++; $display("FAIL two_done_cycle stall=%0d: got %0d expected %0d", stall, done_cyc, last_cyc + 1); end
    n_checks++; if (v_re_empty != 0) begin n_errors++; $display("FAIL re_while_empty stall=%0d: got %0d expected 0", stall, v_re_empty); end
    n_checks++; if (v_re_consec != 0) begin n_errors++; $display("FAIL re_consecutive stall=%0d: got %0d expected 0", stall, v_re_consec); end
    n_checks++; if (v_re_we != 0) begin n_errors++; $display("FAIL re_with_we stall=%0d: got %0d expected 0", stall, v_re_we); end
    n_checks++; if (v_core_early != 0) begin n_errors++; $display("FAIL core_early stall=%0d: got %0d expected 0", stall, v_core_early); end
  endtask

  task automatic test_overflow();
    bit to;
    fifo_q.delete(); exp_q.delete(); stall_max = 0;
    push_word(32'd17); push_word(32'hA5A5A5A5); push_word(32'h5A5A5A5A);
    apply_reset(); release_reset();
    drive(200, 0, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL ovf_timeout: got %b expected 0", to); end
    n_checks++; if (boot_err !== 1'b1) begin n_errors++; $display("FAIL ovf_err: got %b expected 1", boot_err); end
    n_checks++; if (err_cyc != 8) begin n_errors++; $display("FAIL ovf_err_cycle: got %0d expected 8", err_cyc); end
    n_checks++; if (boot_done !== 1'b0) begin n_errors++; $display("FAIL ovf_done: got %b expected 0", boot_done); end
    n_checks++; if (v_core_early != 0 || core_rst_n !== 1'b0) begin n_errors++; $display("FAIL ovf_core: got %b (%0d early) expected 0", core_rst_n, v_core_early); end
    n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL ovf_writes: got %0d expected 0", obs_q.size()); end
    n_checks++; if (re_cnt != 4 || fifo_q.size() != 8) begin n_errors++; $display("FAIL ovf_reads: got %0d reads %0d left expected 4 reads 8 left", re_cnt, fifo_q.size()); end
  endtask

  task automatic test_exact_fill();
    bit to;
    wr_t e, o;
    logic [31:0] w;
    fifo_q.delete(); exp_q.delete(); stall_max = 0;
    push_word(32'd16);
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      push_word(w); push_exp(i, w);
    end
    apply_reset(); release_reset();
    drive(2000, 0, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL fill_timeout: got %b expected 0", to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL fill_missing: no write, expected addr %h data %h", e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          n_errors++; $display("FAIL fill_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL fill_extra: got %0d expected 0", obs_q.size()); end
    n_checks++; if (done_cyc != 152) begin n_errors++; $display("FAIL fill_done_cycle: got %0d expected 152", done_cyc); end
    n_checks++; if (boot_err !== 1'b0) begin n_errors++; $display("FAIL fill_err: got %b expected 0", boot_err); end
  endtask

  task automatic test_reset_midload();
    bit to;
    wr_t e, o;
    fifo_q.delete(); exp_q.delete(); stall_max = 0;
    push_word(32'd2); push_word(32'hCAFEF00D); push_word(32'h0BADC0DE);
    apply_reset(); release_reset();
    drive(200, 10, to);
    n_checks++; if (to !== 1'b0 || obs_q.size() != 1) begin n_errors++; $display("FAIL mid_partial: got timeout %b writes %0d expected 0 and 1", to, obs_q.size()); end
    apply_reset();
    n_checks++; if (bus.imem_we !== 1'b0 || bus.imem_addr !== 4'd0) begin n_errors++; $display("FAIL mid_reset_we_addr: got %b/%h expected 0/0", bus.imem_we, bus.imem_addr); end
    n_checks++; if (bus.imem_wdata !== 32'd0) begin n_errors++; $display("FAIL mid_reset_wdata: got %h expected 0", bus.imem_wdata); end
    n_checks++; if (core_rst_n !== 1'b0 || boot_done !== 1'b0 || boot_err !== 1'b0) begin n_errors++; $display("FAIL mid_reset_status: got %b%b%b expected 000", core_rst_n, boot_done, boot_err); end
    fifo_q.delete();
    push_word(32'd2); push_word(32'h11223344); push_word(32'h55667788);
    push_exp(0, 32'h11223344); push_exp(1, 32'h55667788);
    release_reset();
    drive(400, 0, to);
    n_checks++; if (to !== 1'b0 || boot_done !== 1'b1) begin n_errors++; $display("FAIL mid_reload_done: got timeout %b done %b expected 0/1", to, boot_done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++; $display("FAIL mid_missing: no write, expected addr %h data %h", e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          n_errors++; $display("FAIL mid_write: got %h/%h expected %h/%h", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL mid_extra: got %0d expected 0", obs_q.size()); end
  endtask

  initial begin
    bus.Empty = 1'b1;
    bus.fifo_data_out = 8'h00;
    stall_max = 0;
    test_reset();
    test_len_zero();
    test_two_words(1'b0);
    test_two_words(1'b1);
    test_overflow();
    test_exact_fill();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
